// File: rtl/pre_emphasis_frame_ctrl.sv
// Frame sequencer for the float32 pre-emphasis datapath y(t) = x(t) - a*x(t-1).
// Define PE_FRAME_RESET_EN to zero x(t-1) at the start of every frame.
module pre_emphasis_frame_ctrl #(
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [31:0] s_tdata,
    output logic        pe_tvalid,
    output logic [31:0] pe_cur,
    output logic [31:0] pe_prev,
    input  logic        pe_res_tvalid,
    input  logic [31:0] pe_res_tdata,
    output logic        m_tvalid,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic        err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [15:0] LEN         = 16'(FRAME_LEN);
    localparam logic [15:0] LEN_LAST    = 16'(FRAME_LEN - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_LAST    = 8'(GAP_CYCLES - 1);
    localparam logic [1:0]  AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

    logic [1:0]  state;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;
    logic [15:0] to_cnt;
    logic [7:0]  gap_cnt;
    logic [31:0] prev;
    logic        xfer;
    logic        res_ok;
    logic        res_last;

    assign s_tready = (state == RUN) && (in_cnt < LEN);
    assign busy     = (state != IDLE);
    assign xfer     = s_tvalid && s_tready;
    // A result belongs to the frame only while it is open and not yet fully returned.
    assign res_ok   = pe_res_tvalid && ((state == RUN) || (state == DRAIN)) && (out_cnt < LEN);
    assign res_last = res_ok && (out_cnt == LEN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_cnt    <= 16'd0;
            out_cnt   <= 16'd0;
            to_cnt    <= 16'd0;
            gap_cnt   <= 8'd0;
            prev      <= 32'd0;
            pe_tvalid <= 1'b0;
            pe_cur    <= 32'd0;
            pe_prev   <= 32'd0;
            m_tvalid  <= 1'b0;
            m_tdata   <= 32'd0;
            m_tlast   <= 1'b0;
            frame_cnt <= 16'd0;
            err       <= 1'b0;
        end else begin
            pe_tvalid <= xfer;
            if (xfer) begin
                pe_cur  <= s_tdata;
                pe_prev <= prev;
                prev    <= s_tdata;
                in_cnt  <= in_cnt + 16'd1;
            end

            m_tvalid <= pe_res_tvalid;
            m_tdata  <= pe_res_tdata;
            m_tlast  <= res_last;
            if (pe_res_tvalid && !res_ok) begin
                err <= 1'b1;
            end
            if (res_ok) begin
                out_cnt <= out_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RUN;
                        in_cnt  <= 16'd0;
                        out_cnt <= 16'd0;
                        to_cnt  <= 16'd0;
`ifdef PE_FRAME_RESET_EN
                        prev    <= 32'd0;
`endif
                    end
                end
                RUN: begin
                    if (xfer && (in_cnt == LEN_LAST)) begin
                        state  <= DRAIN;
                        to_cnt <= 16'd0;
                    end
                end
                DRAIN: begin
                    // A lost result abandons the frame without counting it.
                    if (res_last) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= AFTER_FRAME;
                        gap_cnt   <= 8'd0;
                    end else if (res_ok) begin
                        to_cnt <= 16'd0;
                    end else if (to_cnt == TO_LAST) begin
                        err     <= 1'b1;
                        state   <= AFTER_FRAME;
                        gap_cnt <= 8'd0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pre_emphasis_frame_ctrl.sv
// Directed bench for pre_emphasis_frame_ctrl with a 10-cycle datapath model (result = cur ^ prev).
module tb_pre_emphasis_frame_ctrl;
    localparam int LAT = 10;
    localparam logic [31:0] DROP_VAL = 32'h41800000;
`ifdef PE_FRAME_RESET_EN
    localparam logic [31:0] CARRY_F2 = 32'h00000000;
    localparam logic [31:0] CARRY_F3 = 32'h00000000;
`else
    localparam logic [31:0] CARRY_F2 = 32'h40800000;
    localparam logic [31:0] CARRY_F3 = 32'h41000000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        pe_tvalid;
    logic [31:0] pe_cur;
    logic [31:0] pe_prev;
    logic        pe_res_tvalid;
    logic [31:0] pe_res_tdata;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    pre_emphasis_frame_ctrl #(
        .FRAME_LEN (4),
        .GAP_CYCLES(2),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .pe_tvalid    (pe_tvalid),
        .pe_cur       (pe_cur),
        .pe_prev      (pe_prev),
        .pe_res_tvalid(pe_res_tvalid),
        .pe_res_tdata (pe_res_tdata),
        .m_tvalid     (m_tvalid),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .frame_cnt    (frame_cnt),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Datapath model: fixed latency, optional drop of one marked sample, optional injected result.
    logic [LAT-1:0] pipe_v = '0;
    logic [31:0]    pipe_d [LAT];
    logic           drop_en = 1'b0;
    logic           inj_v   = 1'b0;
    logic [31:0]    inj_d   = 32'd0;

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], pe_tvalid && !(drop_en && (pe_cur == DROP_VAL))};
        pipe_d[0] <= pe_cur ^ pe_prev;
        for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end

    assign pe_res_tvalid = pipe_v[LAT-1] | inj_v;
    assign pe_res_tdata  = inj_v ? inj_d : pipe_d[LAT-1];

    // Monitor logs issues and results so tests can inspect them by index.
    int          cyc        = 0;
    int          rdy_cycles = 0;
    int          err_cyc    = -1;
    logic [31:0] iss_cur [$];
    logic [31:0] iss_prev[$];
    logic [31:0] out_data[$];
    logic        out_last[$];
    int          out_cyc [$];

    always @(negedge clk) begin
        cyc++;
        if (pe_tvalid) begin
            iss_cur.push_back(pe_cur);
            iss_prev.push_back(pe_prev);
        end
        if (m_tvalid) begin
            out_data.push_back(m_tdata);
            out_last.push_back(m_tlast);
            out_cyc.push_back(cyc);
        end
        if (s_tready) rdy_cycles++;
        if (err && (err_cyc < 0)) err_cyc = cyc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] samples, input int count, input int spacing);
        int budget;
        for (int i = 0; i < count; i++) begin
            for (int k = 0; k < spacing; k++) begin
                @(negedge clk);
                s_tvalid = 1'b0;
            end
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = samples[32*i +: 32];
            budget   = 0;
            while (!s_tready && (budget < 40)) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 40) checkOutput("tready_wait", 32'(s_tready), 32'd1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic waitFrame(input logic [15:0] target);
        int budget = 0;
        while ((frame_cnt != target) && (budget < 100)) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("frame_cnt_reach", 32'(frame_cnt), 32'(target));
    endtask

    task automatic waitIdle();
        int budget = 0;
        while (busy && (budget < 100)) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("return_idle", 32'(busy), 32'd0);
    endtask

    // Full-frame check: pe_prev chain, result data and tlast placement.
    task automatic checkFrame(input logic [127:0] samples, input logic [31:0] first_prev,
                              input int ib, input int ob);
        logic [31:0] prev_m;
        logic [31:0] cur_m;
        prev_m = first_prev;
        checkOutput("issue_count", 32'(iss_prev.size() - ib), 32'd4);
        checkOutput("result_count", 32'(out_data.size() - ob), 32'd4);
        for (int k = 0; k < 4; k++) begin
            cur_m = samples[32*k +: 32];
            checkOutput("pe_cur", iss_cur[ib+k], cur_m);
            checkOutput("pe_prev", iss_prev[ib+k], prev_m);
            checkOutput("m_tdata", out_data[ob+k], cur_m ^ prev_m);
            checkOutput("m_tlast", 32'(out_last[ob+k]), (k == 3) ? 32'd1 : 32'd0);
            prev_m = cur_m;
        end
    endtask

    initial begin
        logic [127:0] f1;
        logic [127:0] f2;
        logic [127:0] f3;
        logic [127:0] f4;
        int ib;
        int ob;
        int rb;
        f1 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        f2 = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
        f3 = {32'h41400000, 32'h41300000, 32'h41200000, 32'h41100000};
        f4 = {DROP_VAL,     32'h41700000, 32'h41600000, 32'h41500000};

        rst      = 1'b1;
        enable   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tready", 32'(s_tready), 32'd0);
        checkOutput("rst_pe_tvalid", 32'(pe_tvalid), 32'd0);
        checkOutput("rst_pe_cur", pe_cur, 32'd0);
        checkOutput("rst_pe_prev", pe_prev, 32'd0);
        checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_m_tdata", m_tdata, 32'd0);
        checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        $display("[TB] frame 1: 1.0..4.0, enable dropped mid-frame");
        @(negedge clk);
        ib = iss_prev.size(); ob = out_data.size(); rb = rdy_cycles;
        enable = 1'b1;
        applyStimulus(f1, 4, 0);
        enable = 1'b0;
        waitFrame(16'd1);
        checkOutput("gap0_busy", 32'(busy), 32'd1);
        checkOutput("gap0_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        checkOutput("gap1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("idle_after_gap", 32'(busy), 32'd0);
        checkOutput("ready_cycles_f1", 32'(rdy_cycles - rb), 32'd4);
        checkFrame(f1, 32'd0, ib, ob);
        checkOutput("err_f1", 32'(err), 32'd0);

        $display("[TB] frame 2: back-to-back, prev carry check");
        ib = iss_prev.size(); ob = out_data.size();
        enable = 1'b1;
        applyStimulus(f2, 4, 0);
        enable = 1'b0;
        waitFrame(16'd2);
        waitIdle();
        checkFrame(f2, CARRY_F2, ib, ob);

        $display("[TB] frame 3: s_tvalid toggling, held through drain/gap");
        ib = iss_prev.size(); ob = out_data.size();
        enable = 1'b1;
        applyStimulus(f3, 4, 1);
        enable = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            s_tvalid = k[0];
            s_tdata  = 32'hBAD00000;
        end
        s_tvalid = 1'b0;
        waitIdle();
        checkOutput("frame_cnt_f3", 32'(frame_cnt), 32'd3);
        checkFrame(f3, CARRY_F3, ib, ob);
        checkOutput("err_f3", 32'(err), 32'd0);

        $display("[TB] frame 4: last result dropped, timeout");
        ob = out_data.size();
        drop_en = 1'b1;
        enable  = 1'b1;
        applyStimulus(f4, 4, 0);
        enable = 1'b0;
        waitIdle();
        drop_en = 1'b0;
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_results", 32'(out_data.size() - ob), 32'd3);
        checkOutput("timeout_delay", 32'(err_cyc - out_cyc[ob+2]), 32'd8);
        for (int k = 0; k < 3; k++) checkOutput("timeout_no_last", 32'(out_last[ob+k]), 32'd0);
        checkOutput("timeout_frame_cnt", 32'(frame_cnt), 32'd3);

        $display("[TB] reset clears error, then stray result in IDLE");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst2_err", 32'(err), 32'd0);
        checkOutput("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
        inj_v = 1'b1;
        inj_d = 32'hDEADBEEF;
        @(negedge clk);
        inj_v = 1'b0;
        checkOutput("stray_m_tvalid", 32'(m_tvalid), 32'd1);
        checkOutput("stray_m_tdata", m_tdata, 32'hDEADBEEF);
        checkOutput("stray_m_tlast", 32'(m_tlast), 32'd0);
        checkOutput("stray_err", 32'(err), 32'd1);
        checkOutput("stray_busy", 32'(busy), 32'd0);

        $display("[TB] reset after two samples of a frame");
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        applyStimulus(f2, 2, 0);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_tready", 32'(s_tready), 32'd0);
        checkOutput("midrst_pe_tvalid", 32'(pe_tvalid), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        repeat (15) @(negedge clk);
        checkOutput("late_result_err", 32'(err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ib = iss_prev.size(); ob = out_data.size();
        enable = 1'b1;
        applyStimulus(f1, 4, 0);
        enable = 1'b0;
        waitFrame(16'd1);
        waitIdle();
        checkFrame(f1, 32'd0, ib, ob);
        checkOutput("fresh_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
